// File: rtl/free_slot_allocator_pkg.sv
// Shared card-RAM definitions: card word field layout, the reserved-word pattern,
// and the state encodings used by the card-RAM FSMs.
package free_slot_allocator_pkg;

   localparam int CARD_USED_BIT = 31;
   localparam int CARD_SUIT_MSB = 21;
   localparam int CARD_SUIT_LSB = 20;
   localparam int CARD_VAL_MSB  = 19;
   localparam int CARD_VAL_LSB  = 16;
   localparam int CARD_NEXT_MSB = 9;
   localparam int CARD_NEXT_LSB = 0;

   localparam int          NULL_ADDR     = 0;
   localparam logic [31:0] RESERVED_WORD = 32'h8000_0000;

   // Slot allocator states
   typedef enum logic [2:0] {
      ALLOC_IDLE,
      ALLOC_ISSUE,
      ALLOC_WAIT_RD,
      ALLOC_CHECK,
      ALLOC_CLAIM,
      ALLOC_CLAIM_END,
      ALLOC_DONE,
      ALLOC_FAILED
   } alloc_state_t;

   // Card store stage states (downstream of the allocator)
   typedef enum logic [1:0] {
      STORE_IDLE,
      STORE_WRITE,
      STORE_LINK,
      STORE_DONE
   } store_state_t;

   function automatic logic card_is_free(input logic [31:0] word);
      return ~word[CARD_USED_BIT];
   endfunction

endpackage

// File: rtl/free_slot_allocator_if.sv
// Request handshake between the card store stage (master) and the slot allocator (slave).
interface free_slot_allocator_if #(
   parameter int ADDR_W = 10
);
   logic              enable;
   logic              addr_found;
   logic              alloc_failed;
   logic [ADDR_W-1:0] out_address;

   modport master (
      output enable,
      input  addr_found,
      input  alloc_failed,
      input  out_address
   );

   modport slave (
      input  enable,
      output addr_found,
      output alloc_failed,
      output out_address
   );
endinterface

// File: rtl/free_slot_allocator_rd_wait.sv
// rd_wait_counter: after a start pulse, raises done on the latency-th following cycle,
// covering the read latency of the card RAM.
module rd_wait_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] latency,
   output logic             done
);

   logic [CNT_W-1:0] cnt;
   logic             busy;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= latency - CNT_W'(1);
      end else if (busy) begin
         if (cnt == '0)
            busy <= 1'b0;
         else
            cnt <= cnt - CNT_W'(1);
      end
   end

   assign done = busy && (cnt == '0);

endmodule

// File: rtl/free_slot_allocator.sv
// Next-fit allocator of free card words: probes the card RAM from a rotating pointer,
// marks the first free word in use and returns its address. Address 0 is never handed out.
module free_slot_allocator
   import free_slot_allocator_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   free_slot_allocator_if.slave req,
   output logic [ADDR_W-1:0]    ram_address,
   output logic                 ram_clock,
   output logic [DATA_W-1:0]    ram_data,
   output logic                 ram_wren,
   input  logic [DATA_W-1:0]    ram_q
);

   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
   localparam logic [DATA_W-1:0] CLAIM_WORD = DATA_W'(RESERVED_WORD);
   localparam logic [1:0]        RD_LAT     = 2'(RD_LATENCY);

   // Pointer increment that skips the list-null address on wrap
   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] ptr);
      return (ptr == LAST_ADDR) ? FIRST_ADDR : ptr + FIRST_ADDR;
   endfunction

   alloc_state_t      state;
   logic [ADDR_W-1:0] next_ptr;
   logic [ADDR_W-1:0] probe_ptr;
   logic [ADDR_W-1:0] probe_cnt;
   logic              addr_found_r;
   logic              alloc_failed_r;
   logic [ADDR_W-1:0] out_address_r;
   logic              rd_done;

   rd_wait_counter #(
      .CNT_W (2)
   ) u_rd_wait (
      .clock   (clock),
      .reset   (reset),
      .start   (state == ALLOC_ISSUE),
      .latency (RD_LAT),
      .done    (rd_done)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ALLOC_IDLE;
         next_ptr       <= FIRST_ADDR;
         probe_ptr      <= FIRST_ADDR;
         probe_cnt      <= '0;
         addr_found_r   <= 1'b0;
         alloc_failed_r <= 1'b0;
         out_address_r  <= '0;
         ram_address    <= '0;
         ram_data       <= '0;
         ram_wren       <= 1'b0;
      end else begin
         case (state)
            ALLOC_IDLE: begin
               if (req.enable) begin
                  probe_ptr <= next_ptr;
                  probe_cnt <= '0;
                  state     <= ALLOC_ISSUE;
               end
            end

            ALLOC_ISSUE: begin
               ram_address <= probe_ptr;
               state       <= ALLOC_WAIT_RD;
            end

            ALLOC_WAIT_RD: begin
               if (rd_done)
                  state <= ALLOC_CHECK;
            end

            // A probe sequence of DEPTH-1 used words means every real address is taken
            ALLOC_CHECK: begin
               if (card_is_free(ram_q[31:0])) begin
                  ram_data <= CLAIM_WORD;
                  ram_wren <= 1'b1;
                  state    <= ALLOC_CLAIM;
               end else if (probe_cnt + FIRST_ADDR == LAST_ADDR) begin
                  probe_cnt      <= probe_cnt + FIRST_ADDR;
                  alloc_failed_r <= 1'b1;
                  out_address_r  <= '0;
                  state          <= ALLOC_FAILED;
               end else begin
                  probe_cnt <= probe_cnt + FIRST_ADDR;
                  probe_ptr <= wrap_inc(probe_ptr);
                  state     <= ALLOC_ISSUE;
               end
            end

            ALLOC_CLAIM: begin
               ram_wren <= 1'b0;
               state    <= ALLOC_CLAIM_END;
            end

            ALLOC_CLAIM_END: begin
               out_address_r <= probe_ptr;
               next_ptr      <= wrap_inc(probe_ptr);
               addr_found_r  <= 1'b1;
               state         <= ALLOC_DONE;
            end

            // Holding here until enable drops forces a low cycle between requests
            ALLOC_DONE: begin
               if (!req.enable) begin
                  addr_found_r  <= 1'b0;
                  out_address_r <= '0;
                  state         <= ALLOC_IDLE;
               end
            end

            ALLOC_FAILED: begin
               if (!req.enable) begin
                  alloc_failed_r <= 1'b0;
                  state          <= ALLOC_IDLE;
               end
            end

            default: state <= ALLOC_IDLE;
         endcase
      end
   end

   assign req.addr_found   = addr_found_r;
   assign req.alloc_failed = alloc_failed_r;
   assign req.out_address  = out_address_r;
   assign ram_clock        = clock;

endmodule

// File: tb/tb_free_slot_allocator.sv
// Bench for free_slot_allocator: two instances (read latency 1 and 2) on behavioural card RAMs.
module tb_free_slot_allocator;
   import free_slot_allocator_pkg::*;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam logic [DW-1:0] USED = 32'h8000_0000;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   free_slot_allocator_if #(.ADDR_W(AW)) ifa ();
   free_slot_allocator_if #(.ADDR_W(AW)) ifb ();

   logic [AW-1:0] ram_addr_a, ram_addr_b;
   logic          ram_clk_a, ram_clk_b;
   logic [DW-1:0] ram_wd_a, ram_wd_b;
   logic          wren_a, wren_b;
   logic [DW-1:0] q_a, q_b, q1_b;
   logic [DW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_b [DEPTH];

   free_slot_allocator #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut_a (
      .clock(clock), .reset(reset), .req(ifa),
      .ram_address(ram_addr_a), .ram_clock(ram_clk_a), .ram_data(ram_wd_a),
      .ram_wren(wren_a), .ram_q(q_a)
   );

   free_slot_allocator #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut_b (
      .clock(clock), .reset(reset), .req(ifb),
      .ram_address(ram_addr_b), .ram_clock(ram_clk_b), .ram_data(ram_wd_b),
      .ram_wren(wren_b), .ram_q(q_b)
   );

   always @(posedge ram_clk_a) begin
      if (wren_a) mem_a[ram_addr_a] <= ram_wd_a;
      q_a <= mem_a[ram_addr_a];
   end

   always @(posedge ram_clk_b) begin
      if (wren_b) mem_b[ram_addr_b] <= ram_wd_b;
      q1_b <= mem_b[ram_addr_b];
      q_b  <= q1_b;
   end

   int wren_cnt_a = 0, wren_cnt_b = 0, zero_hits_a = 0, zero_hits_b = 0;
   logic [AW-1:0] prev_a = '0, prev_b = '0;

   always @(posedge clock) begin
      if (wren_a) wren_cnt_a <= wren_cnt_a + 1;
      if (wren_b) wren_cnt_b <= wren_cnt_b + 1;
      if (reset) begin
         prev_a <= '0;
         prev_b <= '0;
      end else begin
         if (ram_addr_a == '0 && prev_a != '0) zero_hits_a <= zero_hits_a + 1;
         if (ram_addr_b == '0 && prev_b != '0) zero_hits_b <= zero_hits_b + 1;
         prev_a <= ram_addr_a;
         prev_b <= ram_addr_b;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct {
      int            inst;
      bit            fail;
      logic [AW-1:0] addr;
      int            lat;
      string         tag;
   } exp_t;
   exp_t sbq[$];

   function automatic logic found(input int inst);
      return (inst != 0) ? ifb.addr_found : ifa.addr_found;
   endfunction
   function automatic logic failed(input int inst);
      return (inst != 0) ? ifb.alloc_failed : ifa.alloc_failed;
   endfunction
   function automatic logic [AW-1:0] out_addr(input int inst);
      return (inst != 0) ? ifb.out_address : ifa.out_address;
   endfunction
   function automatic logic wren(input int inst);
      return (inst != 0) ? wren_b : wren_a;
   endfunction
   function automatic logic [AW-1:0] ram_addr(input int inst);
      return (inst != 0) ? ram_addr_b : ram_addr_a;
   endfunction

   task automatic set_en(input int inst, input logic v);
      if (inst != 0) ifb.enable = v;
      else           ifa.enable = v;
   endtask

   task automatic clear_mems();
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset      = 1'b1;
      ifa.enable = 1'b0;
      ifb.enable = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Drive one request; the expectation is queued first and consumed when the DUT answers
   task automatic request(input int inst, input bit fail, input logic [AW-1:0] addr,
                          input int lat, input string tag);
      exp_t e;
      int   cyc;
      bit   seen;
      e.inst = inst; e.fail = fail; e.addr = addr; e.lat = lat; e.tag = tag;
      sbq.push_back(e);
      @(negedge clock);
      set_en(inst, 1'b1);
      cyc  = -1;
      seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         @(posedge clock);
         cyc++;
         #1;
         if (found(inst) || failed(inst)) seen = 1'b1;
      end
      e = sbq.pop_front();
      chk({e.tag, "_answered"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({e.tag, "_failed"}, 32'(failed(e.inst)), 32'(e.fail));
         chk({e.tag, "_found"}, 32'(found(e.inst)), 32'(!e.fail));
         chk({e.tag, "_addr"}, 32'(out_addr(e.inst)), e.fail ? 32'd0 : 32'(e.addr));
         chk({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
         @(posedge clock); #1;
         chk({e.tag, "_hold"}, 32'(e.fail ? failed(e.inst) : found(e.inst)), 32'd1);
      end
      @(negedge clock);
      set_en(inst, 1'b0);
      @(posedge clock); #1;
      chk({e.tag, "_clear"}, {30'd0, found(inst), failed(inst)}, 32'd0);
      chk({e.tag, "_clear_addr"}, 32'(out_addr(inst)), 32'd0);
      @(negedge clock);
   endtask

   task automatic claim_reset(input int inst, input int lat, input string tag);
      bit seen;
      do_reset();
      clear_mems();
      @(negedge clock);
      set_en(inst, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clock); #1;
         if (wren(inst)) seen = 1'b1;
      end
      chk({tag, "_claim_seen"}, 32'(seen), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk({tag, "_wren_async"}, 32'(wren(inst)), 32'd0);
      chk({tag, "_flags"}, {30'd0, found(inst), failed(inst)}, 32'd0);
      chk({tag, "_outs"}, {6'd0, out_addr(inst), 6'd0, ram_addr(inst)}, 32'd0);
      set_en(inst, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      mem_a[1] = '0;
      mem_b[1] = '0;
      request(inst, 1'b0, 10'd1, lat, {tag, "_restart"});
   endtask

   initial begin
      int w0;
      reset      = 1'b1;
      ifa.enable = 1'b0;
      ifb.enable = 1'b0;
      clear_mems();
      do_reset();

      chk("rst_found", 32'(ifa.addr_found), 32'd0);
      chk("rst_failed", 32'(ifa.alloc_failed), 32'd0);
      chk("rst_out_addr", 32'(ifa.out_address), 32'd0);
      chk("rst_wren", 32'(wren_a), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr_a), 32'd0);

      // Empty RAM: first slot, one write of the reserved pattern
      request(0, 1'b0, 10'd1, 5, "t1");
      chk("t1_ram1", mem_a[1], USED);
      chk("t1_wren_cycles", 32'(wren_cnt_a), 32'd1);

      // Next-fit: the freed word 1 is not reused
      mem_a[1] = '0;
      request(0, 1'b0, 10'd2, 5, "t2");
      chk("t2_wren_cycles", 32'(wren_cnt_a), 32'd2);

      // Five used words ahead of the pointer, both read latencies
      do_reset();
      clear_mems();
      for (int i = 1; i <= 5; i++) begin
         mem_a[i] = USED;
         mem_b[i] = USED;
      end
      request(0, 1'b0, 10'd6, 6 * 3 + 2, "t3a");
      request(1, 1'b0, 10'd6, 6 * 4 + 2, "t3b");

      // Park next_ptr at 1023, then wrap past a used 1023 to 1
      do_reset();
      clear_mems();
      for (int i = 1; i <= 1021; i++) mem_a[i] = USED;
      request(0, 1'b0, 10'd1022, 1022 * 3 + 2, "t4a");
      mem_a[1023] = USED;
      mem_a[1]    = '0;
      request(0, 1'b0, 10'd1, 2 * 3 + 2, "t4b");
      chk("t4_zero_probe", 32'(zero_hits_a), 32'd0);

      // Full RAM: failure after DEPTH-1 probes, nothing written, pointer kept
      do_reset();
      clear_mems();
      for (int i = 1; i < DEPTH; i++) mem_a[i] = USED;
      w0 = wren_cnt_a;
      request(0, 1'b1, 10'd0, 1023 * 3, "t5");
      chk("t5_no_write", 32'(wren_cnt_a), 32'(w0));
      mem_a[1] = '0;
      request(0, 1'b0, 10'd1, 5, "t5_next");

      // Reset while the claim write is on the bus
      claim_reset(0, 5, "t6a");
      claim_reset(1, 6, "t6b");
      chk("t6_zero_probe_b", 32'(zero_hits_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
